// File: rtl/generador_rampa_rnm.sv
// Real-valued ramp generator: rises from VSS to VDD in NUM_PASOS steps, holds, falls,
// holds, and repeats for CICLOS periods. Produces the vin stimulus for an inverter model.
module generador_rampa_rnm #(
  parameter real VDD         = 1.8,
  parameter real VSS         = 0.0,
  parameter int  NUM_PASOS   = 10,
  parameter int  HOLD_CICLOS = 5000,
  parameter int  CICLOS      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output real         vout,
  output logic        busy,
  output logic        done,
  output logic [15:0] ciclo_cnt
);

  generate
    if (NUM_PASOS < 1 || HOLD_CICLOS < 1 || CICLOS < 1 || CICLOS > 65535 || VDD <= VSS) begin : g_param_chk
      $fatal(1, "generador_rampa_rnm: illegal parameter set");
    end
  endgenerate

  localparam real         PASO = (VDD - VSS) / real'(NUM_PASOS);
  localparam logic [31:0] NP   = 32'(NUM_PASOS);
  localparam logic [31:0] HC   = 32'(HOLD_CICLOS);
  localparam logic [15:0] CIC  = 16'(CICLOS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SUBIR = 3'd1,
    ALTO  = 3'd2,
    BAJAR = 3'd3,
    BAJO  = 3'd4
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] hold_q, hold_d;
  logic [15:0] cnt_q, cnt_d;
  real         vout_q, vout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        lanzar_s;

  // Next-state and next-output logic for the ramp sequencer.
  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    vout_d   = vout_q;
    done_d   = 1'b0;
    lanzar_s = 1'b0;
    case (estado_q)
      IDLE: begin
        vout_d = VSS;
        if (start && !stop) begin
          cnt_d    = 16'd0;
          lanzar_s = 1'b1;
        end else begin
          idx_d  = 32'd0;
          hold_d = 32'd0;
        end
      end
      SUBIR: begin
        idx_d = idx_q + 32'd1;
        if (idx_d == NP) begin
          vout_d   = VDD;
          hold_d   = 32'd0;
          estado_d = ALTO;
        end else begin
          vout_d = VSS + real'(idx_d) * PASO;
        end
      end
      ALTO: begin
        if (hold_q == HC) begin
          idx_d  = 32'd1;
          hold_d = 32'd0;
          // A single-step ramp lands on the low rail immediately.
          if (NP == 32'd1) begin
            vout_d   = VSS;
            estado_d = BAJO;
          end else begin
            vout_d   = VDD - PASO;
            estado_d = BAJAR;
          end
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      BAJAR: begin
        idx_d = idx_q + 32'd1;
        if (idx_d == NP) begin
          vout_d   = VSS;
          hold_d   = 32'd0;
          estado_d = BAJO;
        end else begin
          vout_d = VDD - real'(idx_d) * PASO;
        end
      end
      BAJO: begin
        if (hold_q == HC) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == CIC) begin
            done_d   = 1'b1;
            idx_d    = 32'd0;
            hold_d   = 32'd0;
            vout_d   = VSS;
            estado_d = IDLE;
          end else begin
            lanzar_s = 1'b1;
          end
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: begin
        idx_d    = 32'd0;
        hold_d   = 32'd0;
        vout_d   = VSS;
        estado_d = IDLE;
      end
    endcase

    // First rising step is taken on the same edge that launches the period.
    if (lanzar_s) begin
      idx_d  = 32'd1;
      hold_d = 32'd0;
      if (NP == 32'd1) begin
        vout_d   = VDD;
        estado_d = ALTO;
      end else begin
        vout_d   = VSS + PASO;
        estado_d = SUBIR;
      end
    end else begin
      idx_d = idx_d;
    end

    if (stop && estado_q != IDLE) begin
      estado_d = IDLE;
      idx_d    = 32'd0;
      hold_d   = 32'd0;
      cnt_d    = cnt_q;
      vout_d   = VSS;
      done_d   = 1'b0;
    end else begin
      cnt_d = cnt_d;
    end

    busy_d = (estado_d != IDLE);
  end

  // State and registered outputs; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= IDLE;
      idx_q    <= 32'd0;
      hold_q   <= 32'd0;
      cnt_q    <= 16'd0;
      vout_q   <= VSS;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      vout_q   <= vout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign vout      = vout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ciclo_cnt = cnt_q;

endmodule
